packet_byte_reader: RTL and testbench

Read-side sequencer for the packet buffer's 64-bit-in / 8-bit-out FIFO. It accepts a packet length descriptor and issues read enables to the FIFO in standard (non-first-word-fall-through) mode. It re-times the one-cycle FIFO read latency into a valid/ready byte stream with an end-of-packet marker. It sits directly downstream of the FIFO wrapper and feeds the packet egress logic.

---
 rtl/packet_buffer_pkg.sv | 26 ++
 rtl/packet_byte_reader_if.sv | 35 +++
 rtl/byte_skid_buffer.sv | 56 +++++
 rtl/packet_byte_reader.sv | 113 +++++++++++
 tb/tb_packet_byte_reader.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/packet_buffer_pkg.sv
// ============================================================================
// Module      : packet_buffer_pkg
// Description : Shared types and constants for the packet byte reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package packet_buffer_pkg;

  localparam int BYTE_WIDTH        = 8;
  localparam int LEN_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } reader_state_e;

  typedef struct packed {
    logic [BYTE_WIDTH-1:0] data;
    logic                  last;
  } buf_entry_t;

endpackage

`default_nettype wire

// File: rtl/packet_byte_reader_if.sv
// ============================================================================
// Module      : packet_byte_reader_if
// Description : Descriptor, FIFO-read and byte-stream signals of the reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface packet_byte_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
);
  logic [LEN_WIDTH-1:0]  len_i;
  logic                  len_valid_i;
  logic                  len_ready_o;
  logic                  fifo_empty_i;
  logic                  fifo_read_en_o;
  logic [DATA_WIDTH-1:0] fifo_data_i;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_valid_o;
  logic                  m_last_o;
  logic                  m_ready_i;
  logic                  busy_o;

  modport master (
    input  len_i, len_valid_i, fifo_empty_i, fifo_data_i, m_ready_i,
    output len_ready_o, fifo_read_en_o, m_data_o, m_valid_o, m_last_o, busy_o
  );

  modport slave (
    output len_i, len_valid_i, fifo_empty_i, fifo_data_i, m_ready_i,
    input  len_ready_o, fifo_read_en_o, m_data_o, m_valid_o, m_last_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/byte_skid_buffer.sv
// ============================================================================
// Module      : byte_skid_buffer
// Description : 2-entry {data,last} FIFO whose head never changes until popped.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_skid_buffer
  import packet_buffer_pkg::*;
(
  input  wire logic       clk_i,
  input  wire logic       rst_ni,
  input  wire logic       push,
  input  wire buf_entry_t push_entry,
  input  wire logic       pop,
  output buf_entry_t      head,
  output logic            valid,
  output logic [1:0]      occ
);

  buf_entry_t r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_occ;

  // Writes land on the slot after the head, so a presented entry is untouched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= push_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({push, pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign valid = (r_occ != 2'd0);
  assign occ   = r_occ;

endmodule

`default_nettype wire

// File: rtl/packet_byte_reader.sv
// ============================================================================
// Module      : packet_byte_reader
// Description : Turns length descriptors into credit-limited FIFO reads and a
//               valid/ready byte stream with end-of-packet marker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module packet_byte_reader
  import packet_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = BYTE_WIDTH,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEFAULT
) (
  input  wire logic            clk_i,
  input  wire logic            rst_ni,
  packet_byte_reader_if.master bus
);

  reader_state_e         r_state;
  reader_state_e         w_next_state;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic                  r_out_of_reset;

  logic [DATA_WIDTH-1:0] w_fifo_byte;
  buf_entry_t            w_push_entry;
  buf_entry_t            w_head;
  logic                  w_valid;
  logic [1:0]            w_occ;
  logic                  w_pop;
  logic                  w_credit;
  logic                  w_read;
  logic                  w_last_read;
  logic                  w_len_ready;
  logic                  w_len_fire;
  logic                  w_busy;

  assign w_pop      = w_valid & bus.m_ready_i;
  // Entries held plus the byte still in flight, net of the one leaving now.
  assign w_credit   = (({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));
  assign w_read     = (r_state == ST_ISSUE) & ~bus.fifo_empty_i & w_credit;
  assign w_last_read = w_read & (r_remaining == LEN_WIDTH'(1));
  assign w_len_fire = bus.len_valid_i & w_len_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_len_fire && (bus.len_i != '0)) w_next_state = ST_ISSUE;
      ST_ISSUE: if (w_last_read)                     w_next_state = ST_DRAIN;
      ST_DRAIN: if (w_pop && w_head.last)            w_next_state = ST_IDLE;
      default:                                       w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_len_ready = (r_state == ST_IDLE) & r_out_of_reset;
    w_busy      = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_out_of_reset  <= 1'b0;
    end else begin
      r_out_of_reset  <= 1'b1;
      r_inflight      <= w_read;
      r_inflight_last <= w_last_read;
      if ((r_state == ST_IDLE) && w_len_fire) begin
        r_remaining <= bus.len_i;
      end else if (w_read) begin
        r_remaining <= r_remaining - LEN_WIDTH'(1);
      end
    end
  end

  // FIFO data is valid the cycle after the read; push it with its tag then.
  assign w_fifo_byte       = bus.fifo_data_i;
  assign w_push_entry.data = w_fifo_byte;
  assign w_push_entry.last = r_inflight_last;

  byte_skid_buffer u_skid (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push       (r_inflight),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .head       (w_head),
    .valid      (w_valid),
    .occ        (w_occ)
  );

  assign bus.len_ready_o    = w_len_ready;
  assign bus.fifo_read_en_o = w_read;
  assign bus.busy_o         = w_busy;
  assign bus.m_data_o       = w_head.data;
  assign bus.m_valid_o      = w_valid;
  assign bus.m_last_o       = w_head.last & w_valid;

endmodule

`default_nettype wire

// File: tb/tb_packet_byte_reader.sv
// ============================================================================
// Module      : tb_packet_byte_reader
// Description : Directed self-checking bench for packet_byte_reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_packet_byte_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  packet_byte_reader_if #(.DATA_WIDTH(8), .LEN_WIDTH(16)) bus ();

  packet_byte_reader #(.DATA_WIDTH(8), .LEN_WIDTH(16)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // Source FIFO model: standard mode, data one cycle after an effective read.
  logic [7:0] fifo_mem [256];
  logic [7:0] fifo_wr = 8'd0;
  logic [7:0] fifo_rd = 8'd0;
  assign bus.fifo_empty_i = (fifo_wr == fifo_rd);
  always @(posedge clk) begin
    if (bus.fifo_read_en_o && !bus.fifo_empty_i) begin
      bus.fifo_data_i <= fifo_mem[fifo_rd];
      fifo_rd         <= fifo_rd + 8'd1;
    end
  end

  // Monitor: logs handshakes and reads, flags unstable data and credit breaches.
  int         cyc = 0;
  int         n_out = 0;
  int         n_rd = 0;
  logic [7:0] out_data [256];
  logic       out_last [256];
  int         out_cyc  [256];
  int         rd_cyc   [256];
  int         outstanding = 0;
  int         stab_err = 0;
  int         credit_err = 0;
  logic       hold_valid = 1'b0;
  logic [7:0] hold_data = 8'd0;
  logic       hold_last = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      outstanding <= 0;
      hold_valid  <= 1'b0;
    end else begin
      if (bus.m_valid_o && bus.m_ready_i) begin
        out_data[n_out] <= bus.m_data_o;
        out_last[n_out] <= bus.m_last_o;
        out_cyc[n_out]  <= cyc;
        n_out           <= n_out + 1;
      end
      if (bus.fifo_read_en_o) begin
        rd_cyc[n_rd] <= cyc;
        n_rd         <= n_rd + 1;
      end
      if (bus.fifo_read_en_o &&
          ((outstanding - int'(bus.m_valid_o && bus.m_ready_i)) >= 2 || bus.fifo_empty_i))
        credit_err <= credit_err + 1;
      if (hold_valid && (!bus.m_valid_o || bus.m_data_o != hold_data || bus.m_last_o != hold_last))
        stab_err <= stab_err + 1;
      outstanding <= outstanding + int'(bus.fifo_read_en_o) - int'(bus.m_valid_o && bus.m_ready_i);
      hold_valid  <= bus.m_valid_o && !bus.m_ready_i;
      hold_data   <= bus.m_data_o;
      hold_last   <= bus.m_last_o;
    end
  end

  task automatic push_byte(input logic [7:0] v);
    fifo_mem[fifo_wr] = v;
    fifo_wr = fifo_wr + 8'd1;
  endtask

  // Presents a descriptor and returns the handshake cycle (-1 on timeout).
  task automatic send_desc(input logic [15:0] len, output int t);
    @(negedge clk);
    bus.len_i = len;
    bus.len_valid_i = 1'b1;
    for (int i = 0; i < 100 && !bus.len_ready_o; i++) @(negedge clk);
    t = bus.len_ready_o ? cyc : -1;
    @(negedge clk);
    bus.len_valid_i = 1'b0;
  endtask

  task automatic wait_out(input int target, input int budget, output bit ok);
    for (int i = 0; i < budget && n_out < target; i++) @(negedge clk);
    ok = (n_out >= target);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    for (int i = 0; i < budget && bus.busy_o; i++) @(negedge clk);
    ok = !bus.busy_o;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total_cnt++; if ({bus.len_ready_o, bus.fifo_read_en_o, bus.m_valid_o, bus.m_last_o, bus.busy_o} !== 5'b0)
      $display("FAIL reset_ctrl: got %b expected 00000", {bus.len_ready_o, bus.fifo_read_en_o, bus.m_valid_o, bus.m_last_o, bus.busy_o});
    else pass_cnt++;
    total_cnt++; if (bus.m_data_o !== 8'h00) $display("FAIL reset_data: got %0h expected 0", bus.m_data_o); else pass_cnt++;
    rst_n = 1'b1;
    #1;
    total_cnt++; if (bus.len_ready_o !== 1'b0) $display("FAIL reset_ready_before_edge: got %b expected 0", bus.len_ready_o); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bus.len_ready_o !== 1'b1) $display("FAIL reset_ready_after_edge: got %b expected 1", bus.len_ready_o); else pass_cnt++;
  endtask

  task automatic test_single_packet();
    int t, base, rbase;
    bit ok;
    base = n_out; rbase = n_rd;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    send_desc(16'd4, t);
    total_cnt++; if (t < 0) $display("FAIL single_desc: got timeout expected handshake"); else pass_cnt++;
    while (cyc < t + 6) @(negedge clk);
    total_cnt++; if (bus.busy_o !== 1'b1) $display("FAIL single_busy_t6: got %b expected 1", bus.busy_o); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL single_busy_t7: got %b expected 0", bus.busy_o); else pass_cnt++;
    wait_out(base + 4, 20, ok);
    total_cnt++; if (n_rd - rbase !== 4) $display("FAIL single_reads: got %0d expected 4", n_rd - rbase); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (rd_cyc[rbase+i] !== t + 1 + i) $display("FAIL single_rd_cyc%0d: got %0d expected %0d", i, rd_cyc[rbase+i], t + 1 + i); else pass_cnt++;
      total_cnt++; if (out_data[base+i] !== 8'(8'h11 * (i + 1))) $display("FAIL single_data%0d: got %0h expected %0h", i, out_data[base+i], 8'(8'h11 * (i + 1))); else pass_cnt++;
      total_cnt++; if (out_cyc[base+i] !== t + 3 + i) $display("FAIL single_out_cyc%0d: got %0d expected %0d", i, out_cyc[base+i], t + 3 + i); else pass_cnt++;
      total_cnt++; if (out_last[base+i] !== (i == 3)) $display("FAIL single_last%0d: got %b expected %b", i, out_last[base+i], (i == 3)); else pass_cnt++;
    end
  endtask

  task automatic test_zero_len();
    int t, base, rbase;
    bit seen_busy = 1'b0;
    base = n_out; rbase = n_rd;
    push_byte(8'hEE);
    send_desc(16'd0, t);
    total_cnt++; if (t < 0) $display("FAIL zero_desc: got timeout expected handshake"); else pass_cnt++;
    total_cnt++; if (bus.len_ready_o !== 1'b1) $display("FAIL zero_ready_next: got %b expected 1", bus.len_ready_o); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      if (bus.busy_o || bus.m_valid_o) seen_busy = 1'b1;
      @(negedge clk);
    end
    total_cnt++; if (seen_busy !== 1'b0) $display("FAIL zero_busy_or_valid: got %b expected 0", seen_busy); else pass_cnt++;
    total_cnt++; if (n_rd - rbase !== 0) $display("FAIL zero_reads: got %0d expected 0", n_rd - rbase); else pass_cnt++;
    total_cnt++; if (n_out - base !== 0) $display("FAIL zero_bytes: got %0d expected 0", n_out - base); else pass_cnt++;
    fifo_wr = fifo_wr - 8'd1;
  endtask

  task automatic test_backpressure();
    int t, base, rbase;
    bit ok;
    base = n_out; rbase = n_rd;
    for (int i = 0; i < 8; i++) push_byte(8'hA0 + 8'(i));
    send_desc(16'd8, t);
    for (int k = 0; k < 200 && n_out < base + 8; k++) begin
      bus.m_ready_i = (k % 4 == 0) || (k % 4 == 3);
      @(negedge clk);
    end
    bus.m_ready_i = 1'b1;
    wait_idle(20, ok);
    total_cnt++; if (n_out - base !== 8) $display("FAIL bp_count: got %0d expected 8", n_out - base); else pass_cnt++;
    total_cnt++; if (n_rd - rbase !== 8) $display("FAIL bp_reads: got %0d expected 8", n_rd - rbase); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      total_cnt++; if ({out_data[base+i], out_last[base+i]} !== {8'hA0 + 8'(i), (i == 7)})
        $display("FAIL bp_byte%0d: got %0h/%b expected %0h/%b", i, out_data[base+i], out_last[base+i], 8'hA0 + 8'(i), (i == 7));
      else pass_cnt++;
    end
    total_cnt++; if (stab_err !== 0) $display("FAIL bp_stable: got %0d expected 0", stab_err); else pass_cnt++;
    total_cnt++; if (credit_err !== 0) $display("FAIL bp_credit: got %0d expected 0", credit_err); else pass_cnt++;
  endtask

  task automatic test_underflow();
    int t, base;
    bit ok;
    base = n_out;
    push_byte(8'h51); push_byte(8'h52); push_byte(8'h53);
    send_desc(16'd6, t);
    while (cyc < t + 10) @(negedge clk);
    total_cnt++; if (n_out - base !== 3) $display("FAIL uf_paused_count: got %0d expected 3", n_out - base); else pass_cnt++;
    total_cnt++; if ({bus.m_valid_o, bus.busy_o} !== 2'b01) $display("FAIL uf_paused_state: got %b expected 01", {bus.m_valid_o, bus.busy_o}); else pass_cnt++;
    push_byte(8'h54); push_byte(8'h55); push_byte(8'h56);
    wait_out(base + 6, 30, ok);
    total_cnt++; if (ok !== 1'b1) $display("FAIL uf_resume: got %0d bytes expected 6", n_out - base); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      total_cnt++; if ({out_data[base+i], out_last[base+i]} !== {8'h51 + 8'(i), (i == 5)})
        $display("FAIL uf_byte%0d: got %0h/%b expected %0h/%b", i, out_data[base+i], out_last[base+i], 8'h51 + 8'(i), (i == 5));
      else pass_cnt++;
    end
    wait_idle(20, ok);
  endtask

  task automatic test_back_to_back();
    int t1, t2, base;
    bit ok;
    base = n_out; t1 = -1; t2 = -1;
    for (int i = 0; i < 5; i++) push_byte(8'h61 + 8'(i));
    @(negedge clk);
    bus.len_i = 16'd2; bus.len_valid_i = 1'b1;
    for (int i = 0; i < 50 && !bus.len_ready_o; i++) @(negedge clk);
    if (bus.len_ready_o) t1 = cyc;
    @(negedge clk);
    bus.len_i = 16'd3;
    for (int i = 0; i < 50 && !bus.len_ready_o; i++) @(negedge clk);
    if (bus.len_ready_o) t2 = cyc;
    total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL b2b_busy_at_accept: got %b expected 0", bus.busy_o); else pass_cnt++;
    @(negedge clk);
    bus.len_valid_i = 1'b0;
    total_cnt++; if (t2 !== t1 + 5) $display("FAIL b2b_accept_cyc: got %0d expected %0d", t2, t1 + 5); else pass_cnt++;
    wait_out(base + 5, 30, ok);
    total_cnt++; if (ok !== 1'b1) $display("FAIL b2b_count: got %0d expected 5", n_out - base); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if ({out_data[base+i], out_last[base+i]} !== {8'h61 + 8'(i), (i == 1 || i == 4)})
        $display("FAIL b2b_byte%0d: got %0h/%b expected %0h/%b", i, out_data[base+i], out_last[base+i], 8'h61 + 8'(i), (i == 1 || i == 4));
      else pass_cnt++;
    end
    total_cnt++; if (out_cyc[base+2] !== t2 + 3) $display("FAIL b2b_second_latency: got %0d expected %0d", out_cyc[base+2], t2 + 3); else pass_cnt++;
    wait_idle(20, ok);
  endtask

  task automatic test_reset_mid_packet();
    int t, base;
    bit ok;
    base = n_out;
    for (int i = 0; i < 8; i++) push_byte(8'h81 + 8'(i));
    send_desc(16'd8, t);
    wait_out(base + 2, 20, ok);
    total_cnt++; if ({bus.m_valid_o, bus.m_data_o} !== {1'b1, 8'h83}) $display("FAIL rst_mid_byte3: got %b/%0h expected 1/83", bus.m_valid_o, bus.m_data_o); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({bus.len_ready_o, bus.fifo_read_en_o, bus.m_valid_o, bus.m_last_o, bus.busy_o, bus.m_data_o} !== 13'b0)
      $display("FAIL rst_mid_async: got %b expected 0", {bus.len_ready_o, bus.fifo_read_en_o, bus.m_valid_o, bus.m_last_o, bus.busy_o, bus.m_data_o});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    fifo_wr = fifo_rd;
    rst_n = 1'b1;
    base = n_out;
    @(negedge clk);
    total_cnt++; if ({bus.len_ready_o, bus.busy_o, bus.m_valid_o} !== 3'b100) $display("FAIL rst_mid_after: got %b expected 100", {bus.len_ready_o, bus.busy_o, bus.m_valid_o}); else pass_cnt++;
    repeat (4) @(negedge clk);
    total_cnt++; if (n_out - base !== 0) $display("FAIL rst_mid_stale: got %0d bytes expected 0", n_out - base); else pass_cnt++;
    push_byte(8'h7E);
    send_desc(16'd1, t);
    wait_out(base + 1, 20, ok);
    total_cnt++; if ({ok, out_data[base], out_last[base]} !== {1'b1, 8'h7E, 1'b1}) $display("FAIL rst_mid_recover: got %b/%0h/%b expected 1/7e/1", ok, out_data[base], out_last[base]); else pass_cnt++;
  endtask

  initial begin
    bus.len_i = '0;
    bus.len_valid_i = 1'b0;
    bus.m_ready_i = 1'b1;
    bus.fifo_data_i = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    test_single_packet();
    test_zero_len();
    test_backpressure();
    test_underflow();
    test_back_to_back();
    test_reset_mid_packet();
    total_cnt++; if (credit_err !== 0 || stab_err !== 0) $display("FAIL final_protocol: got credit=%0d stable=%0d expected 0/0", credit_err, stab_err); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
